// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register:
// mode codes, FSM state encoding and the shift-mode classifier.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Only modes that move bits are legal for a burst.
    function automatic logic is_shift_mode(input logic [2:0] m);
        logic r;
        case (m)
            MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR: r = 1'b1;
            default:                                          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/universal_shift_register_n_if.sv
// Control and data bundle between the host logic and the
// universal shift register.
interface universal_shift_register_n_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             en;
    logic [2:0]       mode;
    logic             left_input;
    logic             right_input;
    logic [WIDTH-1:0] parallel_input;
    logic             burst_start;
    logic [CNT_W-1:0] burst_len;
    logic [WIDTH-1:0] out;
    logic             msb_out;
    logic             lsb_out;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, left_input, right_input,
        output parallel_input, burst_start, burst_len,
        input  out, msb_out, lsb_out, busy, done
    );

    modport slave (
        input  en, mode, left_input, right_input,
        input  parallel_input, burst_start, burst_len,
        output out, msb_out, lsb_out, busy, done
    );
endinterface

// File: rtl/usr_step.sv
// One operation of the universal shift register, purely
// combinational; used by both single-step and burst paths.
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [2:0]       mode,
    input  logic             left_input,
    input  logic             right_input,
    input  logic [WIDTH-1:0] parallel_input,
    output logic [WIDTH-1:0] next_val
);

    always_comb begin
        next_val = cur;
        case (mode)
            MODE_HOLD: next_val = cur;
            MODE_SHR:  next_val = {right_input, cur[WIDTH-1:1]};
            MODE_SHL:  next_val = {cur[WIDTH-2:0], left_input};
            MODE_LOAD: next_val = parallel_input;
            MODE_ROR:  next_val = {cur[0], cur[WIDTH-1:1]};
            MODE_ROL:  next_val = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_ASR:  next_val = {cur[WIDTH-1], cur[WIDTH-1:1]};
            MODE_CLR:  next_val = '0;
            default:   next_val = cur;
        endcase
    end

endmodule

// File: rtl/universal_shift_register_n.sv
// Parametrised universal shift register with an autonomous
// burst sequencer that runs a programmed number of steps.
module universal_shift_register_n
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic                        clk,
    input logic                        clr,
    universal_shift_register_n_if.slave bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             done_q, done_d;

    logic             burst_req;
    logic             burst_go;
    logic             last_step;
    logic [2:0]       step_mode;
    logic [WIDTH-1:0] step_val;

    assign burst_req = bus.burst_start && is_shift_mode(bus.mode);
    assign burst_go  = burst_req && (bus.burst_len != '0);
    assign last_step = (cnt_q == CNT_W'(1));

    // In BUSY the captured mode drives the step; host mode is ignored.
    assign step_mode = (state_q == ST_BUSY) ? mode_q : bus.mode;

    usr_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .cur           (out_q),
        .mode          (step_mode),
        .left_input    (bus.left_input),
        .right_input   (bus.right_input),
        .parallel_input(bus.parallel_input),
        .next_val      (step_val)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_HOLD;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (burst_go) state_d = ST_BUSY;
            ST_BUSY: if (last_step) state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_d  = out_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        done_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (burst_req) begin
                    if (burst_go) begin
                        cnt_d  = bus.burst_len;
                        mode_d = bus.mode;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (bus.en) begin
                    out_d = step_val;
                end
            end
            ST_BUSY: begin
                out_d = step_val;
                cnt_d = cnt_q - CNT_W'(1);
                if (last_step) done_d = 1'b1;
            end
        endcase
    end

    always_comb begin
        bus.out     = out_q;
        bus.msb_out = out_q[WIDTH-1];
        bus.lsb_out = out_q[0];
        bus.busy    = (state_q == ST_BUSY);
        bus.done    = done_q;
    end

endmodule

// File: doc/universal_shift_register_n.md
# universal_shift_register_n

Parametrised universal shift register with rotate and arithmetic modes, synchronous clear, and an autonomous burst sequencer. The burst sequencer performs a programmed number of shift or rotate steps and then signals completion. It sits in the same datapath slot as the 4-bit universal shift register. It adds width generality and multi-step shifting without per-cycle control from the host logic.

## Interface
- WIDTH, 8, register width in bits (≥2)
- CNT_W, $clog2(WIDTH+1), width of burst length / step counter
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous, active-high reset
- en  in  1  single-step enable (IDLE only)
- mode  in  3  operation select (see Operation)
- left_input  in  1  serial bit entering LSB on shift left
- right_input  in  1  serial bit entering MSB on shift right
- parallel_input  in  WIDTH  load value
- burst_start  in  1  request a multi-step burst (IDLE only)
- burst_len  in  CNT_W  number of steps in burst
- out  out  WIDTH  register contents
- msb_out  out  1  out[WIDTH-1], combinational
- lsb_out  out  1  out[0], combinational
- busy  out  1  burst in progress
- done  out  1  one-cycle burst-complete pulse

## Operation
- Modes:
  - 000 hold
  - 001 shift right {right_input, out[W-1:1]}
  - 010 shift left {out[W-2:0], left_input}
  - 011 parallel load
  - 100 rotate right {out[0], out[W-1:1]}
  - 101 rotate left {out[W-2:0], out[W-1]}
  - 110 arithmetic shift right {out[W-1], out[W-1:1]}
  - 111 synchronous clear to 0
- Shift modes are 001, 010, 100, 101, 110.
- FSM states are IDLE and BUSY.
- IDLE, burst_start=1, mode is a shift mode, burst_len>0:
  - capture mode and burst_len
  - set busy=1 and go to BUSY
  - no step occurs on this edge
- IDLE, burst_start=1, shift mode, burst_len=0:
  - no state change and no step
  - done=1 on the next cycle
- IDLE, burst_start=1, non-shift mode: burst_start is ignored and the en rule applies.
- IDLE, burst_start=0:
  - en=1: one op of mode
  - en=0: out holds
- BUSY:
  - every edge performs one step of the captured mode, using live left_input/right_input
  - counter decrements on each step
  - on the step where counter==1, go to IDLE, busy←0, done←1
- BUSY ignores en, mode, burst_start and parallel_input.
- done is high for exactly one cycle.
- A new burst_start may be accepted in the cycle done is high.
- burst_len may exceed WIDTH; every requested step is executed, with no saturation.

## Timing
- Reset (clr=1, asynchronous): out=0, busy=0, done=0, state IDLE, counter=0.
  - takes effect immediately, regardless of clk
- clr during BUSY aborts the burst; done is not asserted.
- Single-step latency: out updates on the first edge with en=1.
- Burst of N≥1 with start on edge 0:
  - busy high after edge 0
  - steps happen on edges 1..N
  - after edge N, busy=0 and done=1
  - done falls after edge N+1 unless re-triggered
- Burst of N=0: done=1 after edge 0, busy stays 0.
- msb_out and lsb_out follow out combinationally, with no extra latency.

## Structure
- Package usr_pkg holds the mode localparams (MODE_HOLD … MODE_CLR), the FSM state encoding, and an is_shift_mode function.
- Sub-module usr_step is purely combinational.
  - inputs: cur, mode, left_input, right_input, parallel_input
  - output: next value
  - shared by the IDLE single-step path and the BUSY burst path
- Top level holds the register, the counter and the FSM.

## Test plan
All scenarios use WIDTH=8 unless noted.
- **Basic modes.** Load 0xA5 (mode 011, en=1) → 0xA5. Shift right with right_input=1 → 0xD2. Shift left with left_input=0 → 0xA4. en=0 for 3 cycles → holds 0xA4.
- **Rotate and ASR.** From 0x81: rotate left → 0x03; reload 0x81, rotate right → 0xC0. ASR of 0x80 → 0xC0. Mode 111 → 0x00.
- **Burst rotate.** out=0x01, mode 101, burst_len=3, start:
  - busy high for 3 cycles, out 0x02→0x04→0x08
  - done high exactly one cycle, after the third step
  - during the burst, drive mode=011 with parallel_input=0xFF → no effect
- **Burst edge cases.**
  - burst_len=0 → done pulse next cycle, busy never high, out unchanged
  - burst_start with mode 011 and en=1 → plain load, busy never high
  - back-to-back burst accepted in the done cycle
- **Reset mid-burst.** Load 0xA5, start a shift-right burst of 5, assert clr asynchronously between edges 2 and 3 → out=0, busy=0 immediately, done never asserted.
- **WIDTH=4 instance.** Load 0b1001, arithmetic shift right burst of 2 → 0b1110. Rotate left → 0b1101.
